jtag_ahb_master: RTL

//  Sequences single-word AHB-Lite transfers on behalf of the JTAG TAP; sits between TAP DR-update logic and the bus.

---
 rtl/jtag_pkg.sv | 21 ++
 rtl/jtag_ahb_wdog.sv | 32 +++
 rtl/jtag_ahb_master.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG-to-AHB bridge: instruction codes,
// AHB transfer encodings and the transfer sequencer state type.
package jtag_pkg;

    localparam logic [3:0] IR_BYPASS = 4'b0000;
    localparam logic [3:0] IR_IDCODE = 4'b1000;
    localparam logic [3:0] IR_ADDR   = 4'b0100;
    localparam logic [3:0] IR_WDATA  = 4'b1100;
    localparam logic [3:0] IR_RDATA  = 4'b0010;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ERR
    } state_t;

endpackage

// File: rtl/jtag_ahb_wdog.sv
// Data-phase wait watchdog: counts HREADY-low cycles and flags the cycle
// in which the TIMEOUT-th consecutive wait occurs.
module jtag_ahb_wdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // expired is asserted during the TIMEOUT-th wait cycle so the sequencer
    // can abort on that same edge
    assign expired = count && (cnt == CW'(TIMEOUT - 1));

    // wait-cycle counter, held at zero outside the data/error phases
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/jtag_ahb_master.sv
// Single-word AHB-Lite master driven by JTAG DR updates (ADDR/WDATA/RDATA).
// Optional build macro: JTAG_AHB_AUTOINC_EN (post-increment address by 4
// after each clean transfer).
module jtag_ahb_master
    import jtag_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IR_SIZE    = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  TCK,
    input  logic                  TRST,
    input  logic [IR_SIZE-1:0]    IR,
    input  logic                  UPDATE_DR,
    input  logic [DATA_WIDTH-1:0] DR_IN,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [3:0]            STATUS,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic                  HWRITE,
    output logic [1:0]            HTRANS,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    input  logic [DATA_WIDTH-1:0] HRDATA
);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  write_q;
    logic                  err_q, ovr_q, to_q;
    logic                  cmd_addr, cmd_wr, cmd_rd;
    logic                  done_ok, done_err, done_to;
    logic                  in_wait_phase, wd_expired;

    assign in_wait_phase = (state == ST_DATA) || (state == ST_ERR);

    jtag_ahb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (TCK),
        .rst     (TRST),
        .clear   (!in_wait_phase),
        .count   (in_wait_phase && !HREADY),
        .expired (wd_expired)
    );

    // instruction decode; updates are only accepted while idle
    always_comb begin
        cmd_addr = 1'b0;
        cmd_wr   = 1'b0;
        cmd_rd   = 1'b0;
        if (UPDATE_DR && (state == ST_IDLE)) begin
            case (IR)
                IR_SIZE'(IR_ADDR):   cmd_addr = 1'b1;
                IR_SIZE'(IR_WDATA):  cmd_wr   = 1'b1;
                IR_SIZE'(IR_RDATA):  cmd_rd   = 1'b1;
                IR_SIZE'(IR_BYPASS),
                IR_SIZE'(IR_IDCODE): ;
                default:             ;
            endcase
        end
    end

    // sequencer state register
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // next-state, bus phase outputs and completion strobes
    always_comb begin
        state_nxt = state;
        HTRANS    = HTRANS_IDLE;
        HWRITE    = 1'b0;
        done_ok   = 1'b0;
        done_err  = 1'b0;
        done_to   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_wr || cmd_rd) state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                HTRANS = HTRANS_NONSEQ;
                HWRITE = write_q;
                if (HREADY) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (HREADY) begin
                    state_nxt = ST_IDLE;
                    done_ok   = 1'b1;
                end else if (wd_expired) begin
                    state_nxt = ST_IDLE;
                    done_to   = 1'b1;
                end else if (HRESP) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_ERR: begin
                if (HREADY) begin
                    state_nxt = ST_IDLE;
                    done_err  = 1'b1;
                end else if (wd_expired) begin
                    state_nxt = ST_IDLE;
                    done_to   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // address/data holding registers, read capture and sticky status flags
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            if (cmd_addr) begin
                addr_q <= ADDR_WIDTH'(DR_IN);
                err_q  <= 1'b0;
                ovr_q  <= 1'b0;
                to_q   <= 1'b0;
            end
            if (cmd_wr) begin
                wdata_q <= DR_IN;
                write_q <= 1'b1;
            end
            if (cmd_rd) write_q <= 1'b0;
            if (UPDATE_DR && (state != ST_IDLE)) ovr_q <= 1'b1;
            if (done_ok && !write_q) rdata_q <= HRDATA;
            if (done_err) err_q <= 1'b1;
            if (done_to)  to_q  <= 1'b1;
`ifdef JTAG_AHB_AUTOINC_EN
            if (done_ok) addr_q <= addr_q + ADDR_WIDTH'(4);
`else
`endif
        end
    end

    assign HADDR  = addr_q;
    assign HWDATA = wdata_q;
    assign RDATA  = rdata_q;
    assign STATUS = {state != ST_IDLE, err_q, ovr_q, to_q};

endmodule
